// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM bank controller.
package sram_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WS,
        WP,
        WH,
        RSP
    } state_t;

    function automatic int bank_w(input int n_banks);
        return (n_banks > 1) ? $clog2(n_banks) : 1;
    endfunction

endpackage

// File: rtl/sram_bank_ctrl_if.sv
// SoC-side request/response port of the SRAM bank controller.
interface sram_bank_ctrl_if
    import sram_pkg::*;
#(
    parameter int BANK_W = 1,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [BANK_W+ADDR_W-1:0] req_addr;
    logic [DATA_W/8-1:0]      req_be;
    logic [DATA_W-1:0]        req_wdata;
    logic                     rsp_valid;
    logic                     rsp_err;
    logic [DATA_W-1:0]        rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/sram_bank_drv.sv
// Registered strobe, address and data stage for one SRAM bank.
module sram_bank_drv #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sel,
    input  logic                  load,
    input  logic                  ce,
    input  logic                  oe,
    input  logic                  we,
    input  logic                  drive,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_dq_o,
    output logic                  sram_dq_oe,
    output logic [DATA_W/8-1:0]   sram_be_n,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    // An unselected bank parks its strobes and holds its last address/data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_be_n  <= '1;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            sram_ce_n  <= ~(sel & ce);
            sram_oe_n  <= ~(sel & oe);
            sram_we_n  <= ~(sel & we);
            sram_dq_oe <= sel & drive;
            sram_be_n  <= (sel & ce) ? ~be : '1;
            if (sel && load) begin
                sram_addr <= addr;
                sram_dq_o <= wdata;
            end
        end
    end

endmodule

// File: rtl/sram_bank_ctrl.sv
// Request front end and access sequencer for N asynchronous SRAM banks.
// state | meaning
// IDLE  | ready for a request, all strobes inactive, bus not driven
// RD    | ce_n/oe_n low for RD_WAIT+1 cycles, data sampled on the last
// WS    | write setup: address/data driven, we_n still high
// WP    | we_n low for WR_WAIT cycles
// WH    | we_n released with data still driven, write response issued
// RSP   | read or out-of-range response, strobes released
module sram_bank_ctrl
    import sram_pkg::*;
#(
    parameter int N_BANKS = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    sram_bank_ctrl_if.slave              bus,
    output logic [N_BANKS*ADDR_W-1:0]    sram_addr,
    input  logic [N_BANKS*DATA_W-1:0]    sram_dq_i,
    output logic [N_BANKS*DATA_W-1:0]    sram_dq_o,
    output logic [N_BANKS-1:0]           sram_dq_oe,
    output logic [N_BANKS*DATA_W/8-1:0]  sram_be_n,
    output logic [N_BANKS-1:0]           sram_ce_n,
    output logic [N_BANKS-1:0]           sram_oe_n,
    output logic [N_BANKS-1:0]           sram_we_n
);

    localparam int BANK_W = bank_w(N_BANKS);
    localparam int BE_W   = DATA_W / 8;

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              ready_q;
    logic [BANK_W-1:0] bank_q, bank_d, req_bank;
    logic [ADDR_W-1:0] req_word;
    logic [BE_W-1:0]   be_q, be_d, req_be_eff;
    logic              accept, req_in_range;
    logic              ce_d, oe_d, we_d, drive_d, rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0] rd_mux;
    logic [N_BANKS-1:0] sel;

    assign {req_bank, req_word} = bus.req_addr;
    assign req_in_range  = 32'(req_bank) < N_BANKS;
    assign accept        = bus.req_valid && ready_q;
    assign bus.req_ready = ready_q;

    // Reads enable every byte lane; req_be only matters for writes.
    assign req_be_eff = bus.req_we ? bus.req_be : '1;
    assign bank_d     = accept ? req_bank : bank_q;
    assign be_d       = accept ? req_be_eff : be_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            wait_q  <= '0;
            ready_q <= 1'b0;
            bank_q  <= '0;
            be_q    <= '1;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                bank_q <= req_bank;
                be_q   <= req_be_eff;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_in_range) begin
                        state_d = RSP;
                    end else if (bus.req_we) begin
                        state_d = WS;
                    end else begin
                        state_d = RD;
                        wait_d  = 4'(RD_WAIT);
                    end
                end
            end
            RD: begin
                if (wait_q == 4'd0) state_d = RSP;
                else                wait_d  = wait_q - 4'd1;
            end
            WS: begin
                state_d = WP;
                wait_d  = 4'(WR_WAIT - 1);
            end
            WP: begin
                if (wait_q == 4'd0) state_d = WH;
                else                wait_d  = wait_q - 4'd1;
            end
            WH:      state_d = IDLE;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe intents for the coming cycle; oe and drive are never both set.
    always_comb begin
        ce_d        = 1'b0;
        oe_d        = 1'b0;
        we_d        = 1'b0;
        drive_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        case (state_d)
            RD: begin
                ce_d = 1'b1;
                oe_d = 1'b1;
            end
            WS: begin
                ce_d    = 1'b1;
                drive_d = 1'b1;
            end
            WP: begin
                ce_d    = 1'b1;
                we_d    = 1'b1;
                drive_d = 1'b1;
            end
            WH: begin
                ce_d        = 1'b1;
                drive_d     = 1'b1;
                rsp_valid_d = 1'b1;
            end
            RSP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = (state_q == IDLE);
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_BANKS; i++) begin
            if (32'(bank_q) == i) rd_mux = sram_dq_i[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_err   <= rsp_err_d;
            bus.rsp_rdata <= (state_q == RD && state_d == RSP) ? rd_mux : '0;
        end
    end

    for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
        assign sel[g] = (32'(bank_d) == g);

        sram_bank_drv #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_drv (
            .clk        (clk),
            .resetn     (resetn),
            .sel        (sel[g]),
            .load       (accept),
            .ce         (ce_d),
            .oe         (oe_d),
            .we         (we_d),
            .drive      (drive_d),
            .be         (be_d),
            .addr       (req_word),
            .wdata      (bus.req_wdata),
            .sram_addr  (sram_addr[g*ADDR_W +: ADDR_W]),
            .sram_dq_o  (sram_dq_o[g*DATA_W +: DATA_W]),
            .sram_dq_oe (sram_dq_oe[g]),
            .sram_be_n  (sram_be_n[g*BE_W +: BE_W]),
            .sram_ce_n  (sram_ce_n[g]),
            .sram_oe_n  (sram_oe_n[g]),
            .sram_we_n  (sram_we_n[g])
        );
    end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench: two-bank controller (RD_WAIT=1, WR_WAIT=2) plus a three-bank one for range errors.
module tb_sram_bank_ctrl;
    import sram_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    sram_bank_ctrl_if #(.BANK_W(bank_w(2)), .ADDR_W(AW), .DATA_W(DW)) bus ();
    sram_bank_ctrl_if #(.BANK_W(bank_w(3)), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

    logic [2*AW-1:0] sram_addr;
    logic [2*DW-1:0] sram_dq_i, sram_dq_o;
    logic [1:0]      sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [7:0]      sram_be_n;

    logic [3*AW-1:0] sram3_addr;
    logic [3*DW-1:0] sram3_dq_i, sram3_dq_o;
    logic [2:0]      sram3_dq_oe, sram3_ce_n, sram3_oe_n, sram3_we_n;
    logic [11:0]     sram3_be_n;

    sram_bank_ctrl #(.N_BANKS(2), .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(1), .WR_WAIT(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_be_n  (sram_be_n),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    sram_bank_ctrl #(.N_BANKS(3), .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(1), .WR_WAIT(1)) dut3 (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus3),
        .sram_addr  (sram3_addr),
        .sram_dq_i  (sram3_dq_i),
        .sram_dq_o  (sram3_dq_o),
        .sram_dq_oe (sram3_dq_oe),
        .sram_be_n  (sram3_be_n),
        .sram_ce_n  (sram3_ce_n),
        .sram_oe_n  (sram3_oe_n),
        .sram_we_n  (sram3_we_n)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc, acc1, lat, clash, rsp_cnt;
    int ce_lo[2], oe_lo[2], we_lo[2], drv_cnt[2];
    logic [7:0]      ws_be_n;
    logic [2*AW-1:0] ws_addr;
    logic [2*DW-1:0] ws_dq;
    logic [31:0]     rd;
    logic            err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        clash = 0;
        rsp_cnt = 0;
        for (int b = 0; b < 2; b++) begin
            ce_lo[b] = 0; oe_lo[b] = 0; we_lo[b] = 0; drv_cnt[b] = 0;
        end
    endtask

    // One clock; samples the two-bank DUT just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int b = 0; b < 2; b++) begin
            if (!sram_ce_n[b]) ce_lo[b]++;
            if (!sram_oe_n[b]) oe_lo[b]++;
            if (!sram_we_n[b]) we_lo[b]++;
            if (sram_dq_oe[b]) drv_cnt[b]++;
            if (sram_dq_oe[b] && !sram_oe_n[b]) clash++;
        end
        if (bus.rsp_valid) rsp_cnt++;
    endtask

    task automatic start_req(input logic we, input logic [AW:0] addr, input logic [3:0] be,
                             input logic [31:0] wd);
        int n;
        n = 0;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        acc_cyc = cyc;
        bus.req_valid = 1'b0;
        ws_be_n = sram_be_n;
        ws_addr = sram_addr;
        ws_dq   = sram_dq_o;
    endtask

    task automatic do_req(input logic we, input logic [AW:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output int l, output logic [31:0] r, output logic e);
        start_req(we, addr, be, wd);
        l = 1;
        while (!bus.rsp_valid && l < 20) begin
            tick();
            l++;
        end
        r = bus.rsp_rdata;
        e = bus.rsp_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_be = '0; bus.req_wdata = '0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0; bus3.req_be = '0; bus3.req_wdata = '0;
        sram_dq_i  = {32'h1111_1111, 32'hDEAD_BEEF};
        sram3_dq_i = {32'h600D_CAFE, 32'h2222_2222, 32'h3333_3333};
        clr();

        // Reset while idle
        #2 resetn = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ce_n",  sram_ce_n, 2'b11);
        check("rst_oe_n",  sram_oe_n, 2'b11);
        check("rst_we_n",  sram_we_n, 2'b11);
        check("rst_be_n",  sram_be_n, 8'hFF);
        check("rst_dq_oe", sram_dq_oe, 2'b00);
        check("rst_addr",  sram_addr, 40'h0);
        check("rst_ready", bus.req_ready, 1'b0);
        check("rst_rsp",   bus.rsp_valid, 1'b0);
        resetn = 1'b1;
        tick();
        check("ready_after_rst", bus.req_ready, 1'b1);

        // Read bank0 @0x00123
        clr();
        do_req(1'b0, {1'b0, 20'h00123}, 4'h0, 32'h0, lat, rd, err);
        check("rd_latency", lat, 3);
        check("rd_data",    rd, 32'hDEAD_BEEF);
        check("rd_err",     err, 1'b0);
        check("rd_addr",    ws_addr[19:0], 20'h00123);
        check("rd_be_n",    ws_be_n[3:0], 4'h0);
        check("rd_ce_lo",   ce_lo[0], 2);
        check("rd_oe_lo",   oe_lo[0], 2);
        check("rd_b1_idle", ce_lo[1] + oe_lo[1] + we_lo[1], 0);
        check("rd_no_drv",  drv_cnt[0], 0);

        // Write bank1 @0xFFFFF, be=0011
        clr();
        do_req(1'b1, {1'b1, 20'hFFFFF}, 4'b0011, 32'hA5A5_1234, lat, rd, err);
        check("wr_latency", lat, 4);
        check("wr_be_n_b1", ws_be_n[7:4], 4'b1100);
        check("wr_be_n_b0", ws_be_n[3:0], 4'hF);
        check("wr_addr_b1", ws_addr[39:20], 20'hFFFFF);
        check("wr_addr_b0_held", ws_addr[19:0], 20'h00123);
        check("wr_dq_o",    ws_dq[63:32], 32'hA5A5_1234);
        check("wr_we_lo",   we_lo[1], 2);
        check("wr_drv_cnt", drv_cnt[1], 4);
        check("wr_ce_lo",   ce_lo[1], 4);
        check("wr_oe_lo",   oe_lo[1], 0);
        check("wr_b0_idle", ce_lo[0] + we_lo[0], 0);
        check("wr_rdata",   rd, 32'h0);
        tick();
        check("wr_idle_dq_oe", sram_dq_oe, 2'b00);
        check("wr_idle_ce_n",  sram_ce_n, 2'b11);

        // Write then read bank0 back-to-back
        clr();
        do_req(1'b1, {1'b0, 20'h00010}, 4'hF, 32'hCAFE_F00D, lat, rd, err);
        acc1 = acc_cyc;
        check("b2b_wr_latency", lat, 4);
        sram_dq_i[31:0] = 32'h0BAD_F00D;
        do_req(1'b0, {1'b0, 20'h00010}, 4'h0, 32'h0, lat, rd, err);
        check("b2b_spacing", acc_cyc - acc1, 5);
        check("b2b_rd_data", rd, 32'h0BAD_F00D);
        check("b2b_clash",   clash, 0);

        // Out-of-range bank on the three-bank controller
        bus3.req_we = 1'b0;
        bus3.req_addr = {2'd3, 20'h00055};
        bus3.req_valid = 1'b1;
        check("err_ready", bus3.req_ready, 1'b1);
        tick();
        bus3.req_valid = 1'b0;
        check("err_rsp_valid", bus3.rsp_valid, 1'b1);
        check("err_rsp_err",   bus3.rsp_err, 1'b1);
        check("err_rdata",     bus3.rsp_rdata, 32'h0);
        check("err_ce_n",      sram3_ce_n, 3'b111);
        check("err_oe_n",      sram3_oe_n, 3'b111);
        tick();
        check("err_rsp_done",  bus3.rsp_valid, 1'b0);
        check("err_ready_again", bus3.req_ready, 1'b1);

        // In-range read of bank2 on the same controller
        bus3.req_addr = {2'd2, 20'h00001};
        bus3.req_valid = 1'b1;
        tick();
        bus3.req_valid = 1'b0;
        check("b2_ce_n", sram3_ce_n, 3'b011);
        tick();
        tick();
        check("b2_rsp_valid", bus3.rsp_valid, 1'b1);
        check("b2_rsp_err",   bus3.rsp_err, 1'b0);
        check("b2_rdata",     bus3.rsp_rdata, 32'h600D_CAFE);

        // Reset during the write pulse
        clr();
        start_req(1'b1, {1'b1, 20'h00AAA}, 4'hF, 32'h1234_5678);
        tick();
        check("abort_in_wp", sram_we_n, 2'b01);
        #3 resetn = 1'b0;
        #1;
        check("abort_we_n",  sram_we_n, 2'b11);
        check("abort_ce_n",  sram_ce_n, 2'b11);
        check("abort_dq_oe", sram_dq_oe, 2'b00);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check("abort_no_rsp", rsp_cnt, 0);
        check("abort_ready",  bus.req_ready, 1'b1);
        sram_dq_i[63:32] = 32'h1357_9BDF;
        do_req(1'b0, {1'b1, 20'h00AAA}, 4'h0, 32'h0, lat, rd, err);
        check("post_abort_latency", lat, 3);
        check("post_abort_rdata",   rd, 32'h1357_9BDF);
        check("post_abort_err",     err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
